// File: rtl/bitwise_logic_unit.sv
// Multicycle bitwise logic unit: AND/OR/XOR/NOR, CHUNK bits per cycle.
// Valid/ready on both sides; zero/ones flags on the held result.
module bitwise_logic_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic [1:0]       ctrl_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             flag_zero,
  output logic             flag_ones
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ones_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cr;
  logic [WIDTH-1:0] acc_d;

  // Select the current chunk of both latched operands.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Apply the latched opcode to the current chunk.
  always_comb begin
    cr = '0;
    unique case (op_q)
      2'b00: cr = ca & cb;
      2'b01: cr = ca | cb;
      2'b10: cr = ca ^ cb;
      2'b11: cr = ~(ca | cb);
      default: cr = '0;
    endcase
  end

  // Merge the chunk result into the accumulator image.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        acc_d[i*CHUNK +: CHUNK] = cr;
      end
    end
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= data_A;
            b_q        <= data_B;
            op_q       <= ctrl_op;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            res_q       <= acc_d;
            zero_q      <= ~|acc_d;
            ones_q      <= &acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign data_result = res_q;
  assign flag_zero   = zero_q;
  assign flag_ones   = ones_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Bench for bitwise_logic_unit: three instances (CHUNK 8, 32, 1)
// share stimulus; per-instance scoreboards check result, flags, latency.
module tb_bitwise_logic_unit;

  typedef struct {
    logic [31:0] res;
    bit          z;
    bit          o;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] data_A = '0;
  logic [31:0] data_B = '0;
  logic [1:0]  ctrl_op = '0;

  logic [2:0]  ir_a;
  logic [2:0]  ov_a;
  logic [2:0]  fz_a;
  logic [2:0]  fo_a;
  logic [31:0] res_a [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int CH = (gi == 0) ? 8 : ((gi == 1) ? 32 : 1);
    localparam int N = 32 / CH;
    exp_t q[$];
    exp_t cur;
    bit   have;

    bitwise_logic_unit #(
      .WIDTH(32),
      .CHUNK(CH)
    ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (ir_a[gi]),
      .data_A     (data_A),
      .data_B     (data_B),
      .ctrl_op    (ctrl_op),
      .out_valid  (ov_a[gi]),
      .out_ready  (out_ready),
      .data_result(res_a[gi]),
      .flag_zero  (fz_a[gi]),
      .flag_ones  (fo_a[gi])
    );

    always @(negedge clock) begin
      if (reset || !ov_a[gi]) begin
        have = 1'b0;
      end else begin
        if (!have) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_out inst%0d got res %h expected none",
                     gi, res_a[gi]);
          end else begin
            cur = q.pop_front();
            have = 1'b1;
            if (cyc - cur.acc != N) begin
              errors++;
              $display("FAIL latency inst%0d got %0d expected %0d",
                       gi, cyc - cur.acc, N);
            end
          end
        end
        if (have) begin
          checks++;
          if (res_a[gi] !== cur.res || fz_a[gi] !== cur.z ||
              fo_a[gi] !== cur.o) begin
            errors++;
            $display("FAIL result inst%0d got %h z%b o%b expected %h z%b o%b",
                     gi, res_a[gi], fz_a[gi], fo_a[gi],
                     cur.res, cur.z, cur.o);
          end
        end
      end
    end
  end

  function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                 logic [1:0] op);
    exp_t e;
    case (op)
      2'd0: e.res = a & b;
      2'd1: e.res = a | b;
      2'd2: e.res = a ^ b;
      default: e.res = ~(a | b);
    endcase
    e.z = (e.res == 32'd0);
    e.o = (e.res == 32'hFFFF_FFFF);
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op);
    exp_t e;
    int n;
    n = 0;
    while (!(&ir_a) && n < 200) begin
      if (n == 3) out_ready = 1'b1;
      @(negedge clock);
      n++;
    end
    chk("issue_wait_idle", {31'd0, &ir_a}, 32'd1);
    e = model(a, b, op);
    e.acc = cyc + 1;
    g[0].q.push_back(e);
    g[1].q.push_back(e);
    g[2].q.push_back(e);
    data_A = a;
    data_B = b;
    ctrl_op = op;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    data_A = $urandom;
    data_B = $urandom;
    ctrl_op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_all();
    int n;
    n = 0;
    while (!((&ir_a) && g[0].q.size() == 0 && g[1].q.size() == 0 &&
             g[2].q.size() == 0) && n < 300) begin
      if (n == 3) out_ready = 1'b1;
      @(negedge clock);
      n++;
    end
    chk("drain_timeout", {31'd0, n >= 300}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'hAAAA_5555;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), {31'd0, ir_a[i]}, 32'd1);
      chk($sformatf("rst_out_valid%0d", i), {31'd0, ov_a[i]}, 32'd0);
      chk($sformatf("rst_result%0d", i), res_a[i], 32'd0);
      chk($sformatf("rst_fz%0d", i), {31'd0, fz_a[i]}, 32'd0);
      chk($sformatf("rst_fo%0d", i), {31'd0, fo_a[i]}, 32'd0);
    end

    issue(32'hF0F0_0000, 32'h0F0F_00FF, 2'b01);
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10);
    issue(32'h0000_0000, 32'h0000_0000, 2'b11);
    issue(32'hFFFF_0000, 32'h0FF0_0FF0, 2'b00);
    wait_all();

    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h0F0F_0F0F, 2'b10);
    n = 0;
    while (!(&ov_a) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("bp_reach_done", {31'd0, &ov_a}, 32'd1);
    repeat (3) begin
      chk("bp_in_ready", {29'd0, ir_a}, 32'd0);
      chk("bp_out_valid", {29'd0, ov_a}, 32'd7);
      in_valid = 1'b1;
      data_A = $urandom;
      data_B = $urandom;
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_in_ready", {29'd0, ir_a}, 32'd7);
    chk("bp_release_out_valid", {29'd0, ov_a}, 32'd0);
    wait_all();

    issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b01);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", {29'd0, ir_a}, 32'd7);
    chk("abort_out_valid", {29'd0, ov_a}, 32'd0);
    chk("abort_fz", {29'd0, fz_a}, 32'd0);
    chk("abort_fo", {29'd0, fo_a}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_result%0d", i), res_a[i], 32'd0);
    end
    g[0].q.delete();
    g[1].q.delete();
    g[2].q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue(32'hC3C3_3C3C, 32'h0F0F_F0F0, 2'b11);
    wait_all();

    repeat (30) begin
      out_ready = ($urandom_range(0, 3) != 0);
      issue(pick(), pick(), 2'($urandom_range(0, 3)));
    end
    wait_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
